// File: rtl/quadrature_decoder.sv
// Quadrature decoder: synchronizes an asynchronous A/B pair, decodes Gray-code
// transitions into cw/ccw step pulses and keeps a wrapping signed position count.
module quadrature_decoder #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   A,
  input  logic                   B,
  input  logic                   clear,
  output logic                   step_cw,
  output logic                   step_ccw,
  output logic                   dir,
  output logic [COUNT_WIDTH-1:0] position,
  output logic                   error
);

  localparam int unsigned QW = 2;

  logic [SYNC_STAGES-1:0] r_a_sync;
  logic [SYNC_STAGES-1:0] r_b_sync;
  logic [QW-1:0]          r_prev;
  logic [QW-1:0]          w_cur;
  logic                   w_is_cw;
  logic                   w_is_ccw;
  logic                   w_is_err;

  logic                   r_step_cw;
  logic                   r_step_ccw;
  logic                   r_dir;
  logic [COUNT_WIDTH-1:0] r_position;
  logic                   r_error;

  assign w_cur = {r_a_sync[SYNC_STAGES-1], r_b_sync[SYNC_STAGES-1]};

  // Synchronizer chains and previous-quadrant register; reset quadrant is 00.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_sync <= '0;
      r_b_sync <= '0;
      r_prev   <= '0;
    end else begin
      r_a_sync <= {r_a_sync[SYNC_STAGES-2:0], A};
      r_b_sync <= {r_b_sync[SYNC_STAGES-2:0], B};
      r_prev   <= w_cur;
    end
  end

  // Transition classifier over {prev, cur}; cw order is 00 -> 10 -> 11 -> 01.
  always_comb begin
    w_is_cw  = 1'b0;
    w_is_ccw = 1'b0;
    w_is_err = 1'b0;
    case ({r_prev, w_cur})
      4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: w_is_cw  = 1'b1;
      4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: w_is_ccw = 1'b1;
      4'b00_11, 4'b11_00, 4'b10_01, 4'b01_10: w_is_err = 1'b1;
      default: ;
    endcase
  end

  // Registered outputs; clear wins over count and error updates but not pulses/dir.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_step_cw  <= 1'b0;
      r_step_ccw <= 1'b0;
      r_dir      <= 1'b0;
      r_position <= '0;
      r_error    <= 1'b0;
    end else begin
      r_step_cw  <= w_is_cw;
      r_step_ccw <= w_is_ccw;
      if (w_is_cw) begin
        r_dir <= 1'b1;
      end else if (w_is_ccw) begin
        r_dir <= 1'b0;
      end
      if (clear) begin
        r_position <= '0;
        r_error    <= 1'b0;
      end else begin
        if (w_is_cw) begin
          r_position <= r_position + COUNT_WIDTH'(1);
        end else if (w_is_ccw) begin
          r_position <= r_position - COUNT_WIDTH'(1);
        end
        if (w_is_err) begin
          r_error <= 1'b1;
        end
      end
    end
  end

  assign step_cw  = r_step_cw;
  assign step_ccw = r_step_ccw;
  assign dir      = r_dir;
  assign position = r_position;
  assign error    = r_error;

endmodule

// File: tb/tb_quadrature_decoder.sv
// Bench for quadrature_decoder: quadrant-index model checked every cycle plus
// hand-computed literal expectations for each directed scenario.
module tb_quadrature_decoder;

  localparam int unsigned SS = 2;
  localparam int unsigned CW = 16;
  localparam int MODV = 65536;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          A = 1'b0;
  logic          B = 1'b0;
  logic          clear = 1'b0;
  logic          step_cw;
  logic          step_ccw;
  logic          dir;
  logic [CW-1:0] position;
  logic          error;

  int n_checks = 0;
  int n_errors = 0;
  int q = 0;

  quadrature_decoder #(.SYNC_STAGES(SS), .COUNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .A(A), .B(B), .clear(clear),
    .step_cw(step_cw), .step_ccw(step_ccw), .dir(dir),
    .position(position), .error(error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Quadrant position along the cw cycle: 00=0, 10=1, 11=2, 01=3.
  function automatic int quad_idx(input logic [1:0] ab);
    if (ab[1]) return ab[0] ? 2 : 1;
    return ab[0] ? 3 : 0;
  endfunction

  function automatic logic [1:0] quad_code(input int idx);
    logic [1:0] codes [4];
    codes[0] = 2'b00; codes[1] = 2'b10; codes[2] = 2'b11; codes[3] = 2'b01;
    return codes[idx % 4];
  endfunction

  // Model: sample history per edge; decode sample k-SS against k-SS-1.
  logic [1:0] hist [SS+2];
  logic exp_cw = 1'b0, exp_ccw = 1'b0, exp_dir = 1'b0, exp_err = 1'b0;
  int   exp_pos = 0;

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < SS + 2; i++) hist[i] = 2'b00;
      exp_cw = 1'b0; exp_ccw = 1'b0; exp_dir = 1'b0; exp_err = 1'b0; exp_pos = 0;
    end else begin
      int d;
      logic clr;
      clr = clear;
      for (int i = SS + 1; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = {A, B};
      d = (quad_idx(hist[SS]) - quad_idx(hist[SS+1]) + 4) % 4;
      exp_cw  = (d == 1);
      exp_ccw = (d == 3);
      if (d == 1) begin exp_dir = 1'b1; exp_pos = (exp_pos + 1) % MODV; end
      if (d == 3) begin exp_dir = 1'b0; exp_pos = (exp_pos + MODV - 1) % MODV; end
      if (d == 2) exp_err = 1'b1;
      if (clr) begin exp_pos = 0; exp_err = 1'b0; end
      #1;
      if (rst_n) begin
        chk("cycle", {27'd0, step_cw, step_ccw, dir, error, 1'b0} | {position, 16'd0},
            {27'd0, exp_cw, exp_ccw, exp_dir, exp_err, 1'b0} | {exp_pos[15:0], 16'd0});
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; A = 1'b0; B = 1'b0; clear = 1'b0; q = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic set_q(input int nq);
    logic [1:0] c;
    q = nq % 4;
    c = quad_code(q);
    A = c[1]; B = c[0];
  endtask

  // n legal steps, one quadrant change every `hold` cycles.
  task automatic steps(input bit cw, input int n, input int hold);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      set_q(cw ? q + 1 : q + 3);
      repeat (hold - 1) @(negedge clk);
    end
  endtask

  task automatic settle();
    repeat (SS + 3) @(negedge clk);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #1;
    chk("reset_outputs", {27'd0, step_cw, step_ccw, dir, error} | {position, 16'd0}, 32'd0);
    do_reset();

    // Four cw steps; first one checked for 3-edge latency
    @(negedge clk);
    set_q(1);
    @(posedge clk); #1 chk("lat_edge0", step_cw, 0);
    @(posedge clk); #1 chk("lat_edge1", step_cw, 0);
    @(posedge clk); #1 chk("lat_edge2", step_cw, 1);
    steps(1'b1, 3, 4);
    settle();
    chk("cw4_pos", position, 4);
    chk("cw4_dir", dir, 1);
    chk("cw4_err", error, 0);

    // Eight ccw steps from reset
    do_reset();
    steps(1'b0, 8, 2);
    settle();
    chk("ccw8_pos", position, 16'hFFF8);
    chk("ccw8_dir", dir, 0);

    // Illegal jump 10 -> 01, sticky error until clear
    do_reset();
    steps(1'b1, 1, 4);
    @(negedge clk); set_q(3);
    settle();
    chk("illegal_err", error, 1);
    chk("illegal_pos", position, 1);
    steps(1'b1, 2, 4);
    settle();
    chk("sticky_err", error, 1);
    chk("sticky_pos", position, 3);
    @(negedge clk); clear = 1'b1;
    @(negedge clk); clear = 1'b0;
    chk("clear_err", error, 0);
    chk("clear_pos", position, 0);

    // Wrap boundary at maximum input rate
    do_reset();
    steps(1'b1, 32767, 1);
    settle();
    chk("pos_7fff", position, 16'h7FFF);
    steps(1'b1, 1, 1);
    settle();
    chk("pos_8000", position, 16'h8000);
    steps(1'b0, 32768, 1);
    settle();
    chk("pos_back0", position, 0);

    // Clear coinciding with a landing cw step
    do_reset();
    @(negedge clk); set_q(2);
    settle();
    chk("err_from_11", error, 1);
    steps(1'b1, 5, 3);
    settle();
    chk("pre_clear_pos", position, 5);
    @(negedge clk); set_q(q + 1);
    @(posedge clk); @(posedge clk);
    @(negedge clk); clear = 1'b1;
    @(posedge clk); #1;
    chk("clr_step_cw", step_cw, 1);
    chk("clr_pos", position, 0);
    chk("clr_err", error, 0);
    chk("clr_dir", dir, 1);
    @(negedge clk); clear = 1'b0;

    // Encoder-style stream: 10 cw then 3 ccw, one pulse every 5 cycles
    do_reset();
    steps(1'b1, 10, 5);
    steps(1'b0, 3, 5);
    settle();
    chk("enc_pos", position, 7);
    chk("enc_err", error, 0);
    chk("enc_dir", dir, 0);
    steps(1'b1, 2, 5);
    @(posedge clk); #2;
    rst_n = 1'b0; A = 1'b0; B = 1'b0; q = 0;
    #1;
    chk("async_rst", {27'd0, step_cw, step_ccw, dir, error} | {position, 16'd0}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    settle();
    chk("post_rst_pos", position, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/quadrature_decoder.md
# quadrature_decoder

Receive-side counterpart of the quadrature encoder: samples an asynchronous A/B quadrature pair, decodes each legal Gray-code transition into a clockwise or counter-clockwise step, and tracks a wrapping signed position count. Illegal double-bit transitions are flagged and never counted. The block sits between an external or on-chip encoder source and any consumer of position, step, or direction information.

## Interface
- `SYNC_STAGES`, default 2: synchronizer flops per input, legal range 2..4.
- `COUNT_WIDTH`, default 16: width of the position counter, two's complement.

- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `A`  in  1  quadrature channel A, asynchronous to `clk`.
- `B`  in  1  quadrature channel B, asynchronous to `clk`.
- `clear`  in  1  synchronous clear of `position` and `error`.
- `step_cw`  out  1  one-cycle pulse per legal clockwise transition.
- `step_ccw`  out  1  one-cycle pulse per legal counter-clockwise transition.
- `dir`  out  1  direction of the last legal step: 1 = clockwise, 0 = counter-clockwise.
- `position`  out  COUNT_WIDTH  signed step count.
- `error`  out  1  sticky illegal-transition flag.

## Operation
- Quadrant code is {A,B}. The clockwise sequence is 00 -> 10 -> 11 -> 01 -> 00. The counter-clockwise sequence is the reverse.
- A and B each pass through a `SYNC_STAGES` flop chain. `prev` holds the previous synchronized {A,B}. `cur` is the last synchronizer stage.
- Decode of (`prev`, `cur`) on every cycle:
  - Equal: no step. All pulses are 0 and all state holds.
  - Clockwise successor: `step_cw`=1, `position`+1, `dir`=1.
  - Counter-clockwise successor: `step_ccw`=1, `position`-1, `dir`=0.
  - Both bits differ (00<->11 or 10<->01): `error`=1 (sticky), no pulse, `position` and `dir` unchanged.
- `prev` <= `cur` every cycle, including error cycles. The decoder resynchronizes to the new quadrant.
- `step_cw` and `step_ccw` are never both 1.
- `position` wraps modulo 2^COUNT_WIDTH. +1 from 0x7FFF gives 0x8000. -1 from 0 gives 0xFFFF (width 16).
- `clear`=1 sets `position` to 0 and `error` to 0 on that edge.
  - `clear` overrides a simultaneous count update or error set.
  - Step pulses and `dir` still update normally in that cycle.
- Reset state:
  - All synchronizer flops and `prev` = 00. This matches the encoder's reset quadrant, so no spurious step occurs after release.
  - `step_cw`, `step_ccw`, `dir`, `error` = 0. `position` = 0.
- Assertion of `rst_n` mid-operation returns everything to the reset state immediately, without waiting for a clock edge.
- If {A,B} is not 00 at reset release, the first synchronized sample compares against `prev`=00 and is decoded normally. A value of 11 therefore raises `error`.

## Timing
- All outputs are registered.
- A/B change first captured at edge n: `cur` updates at edge n+SYNC_STAGES-1. `step_*`, `position`, `dir`, and `error` update at edge n+SYNC_STAGES.
- Latency is 3 edges for the default `SYNC_STAGES`=2.
- `step_*` is high for exactly one cycle per transition.
- Back-to-back transitions on consecutive sampled cycles each produce their own pulse. Maximum decodable input rate is one quadrant change per clock.
- `clear` takes effect on the edge at which it is sampled high. There is no synchronizer on `clear`.

## Test plan
- Reset, then drive 00->10->11->01->00, holding each code for 4 cycles -> four `step_cw` pulses, each 3 edges after the input change; `position`=4, `dir`=1, `error`=0.
- From reset, apply 8 counter-clockwise transitions -> eight `step_ccw` pulses; `position`=0xFFF8, `dir`=0.
- From quadrant 10, jump directly to 01 -> no pulse, `position` unchanged, `error`=1. `error` stays 1 through subsequent legal steps until `clear`.
- Preload `position` to 0x7FFF using 32767 clockwise steps, then one more clockwise step -> `position`=0x8000. Then 0x8000 counter-clockwise steps -> `position` returns to 0.
- Assert `clear` on the same edge a `step_cw` lands, with `position`=5 and `error`=1 -> `position`=0, `error`=0, `step_cw` pulse still emitted, `dir`=1.
- Chain with the quadrature encoder model sharing `clk`/`rst_n`:
  - 10 clockwise pulses, then 3 counter-clockwise pulses, one pulse every 5 cycles -> `position`=7, `error`=0.
  - Assert `rst_n` mid-sequence -> all outputs return to 0 asynchronously.
